// File: rtl/hazard_stall_ctrl_if.sv
// Signal bundle between the pipeline (master) and the hazard/stall controller (slave).
// Carries ID/EX hazard inputs, branch resolution, stall/flush controls and mul/div status.
interface hazard_stall_ctrl_if #(
  parameter int CNTW = 16
);
  logic            id_valid;
  logic [3:0]      id_op1;
  logic [3:0]      id_op2;
  logic            id_r15use;
  logic            id_is_mul;
  logic            id_is_div;
  logic [3:0]      id_dest;
  logic            ex_memread;
  logic [3:0]      ex_dest;
  logic            branch_taken;
  logic            pc_stall;
  logic            ifid_stall;
  logic            idex_bubble;
  logic            ifid_flush;
  logic            md_start;
  logic            md_busy;
  logic            md_done;
  logic [CNTW-1:0] stall_count;

  modport master (
    output id_valid, id_op1, id_op2, id_r15use, id_is_mul, id_is_div, id_dest,
           ex_memread, ex_dest, branch_taken,
    input  pc_stall, ifid_stall, idex_bubble, ifid_flush,
           md_start, md_busy, md_done, stall_count
  );

  modport slave (
    input  id_valid, id_op1, id_op2, id_r15use, id_is_mul, id_is_div, id_dest,
           ex_memread, ex_dest, branch_taken,
    output pc_stall, ifid_stall, idex_bubble, ifid_flush,
           md_start, md_busy, md_done, stall_count
  );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Load-use stall, mul/div occupancy sequencing, branch flush and saturating stall counter
// for the 16-register 5-stage core.
module hazard_stall_ctrl #(
  parameter int MULCYC = 4,
  parameter int DIVCYC = 8,
  parameter int CNTW   = 16
) (
  input  logic              clk,
  input  logic              rst,
  hazard_stall_ctrl_if.slave bus
);
  localparam int MAXCYC = (MULCYC > DIVCYC) ? MULCYC : DIVCYC;
  localparam int CW     = (MAXCYC > 1) ? $clog2(MAXCYC) : 1;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t          state, state_nx;
  logic [CW-1:0]   cnt, cnt_nx;
  logic [3:0]      md_dest, md_dest_nx;
  logic [CNTW-1:0] stall_count;
  logic            loaduse, busyhaz, stall, start, done;

  // NOTE: every signal gets a default at the top of always_comb so no path leaves it unassigned (no latch).
  always_comb begin
    loaduse    = bus.ex_memread & ((bus.ex_dest == bus.id_op1) | (bus.ex_dest == bus.id_op2) |
                                   (bus.id_r15use & (bus.ex_dest == 4'hF)));
    // While the unit is busy, ID must wait on any mul/div, its result register or R15.
    busyhaz    = (state == BUSY) & (bus.id_is_mul | bus.id_is_div |
                                    (bus.id_op1 == md_dest) | (bus.id_op2 == md_dest) |
                                    bus.id_r15use | (bus.id_op1 == 4'hF) | (bus.id_op2 == 4'hF));
    stall      = bus.id_valid & ~bus.branch_taken & (loaduse | busyhaz);
    start      = bus.id_valid & ~bus.branch_taken & ~stall & (bus.id_is_mul | bus.id_is_div);
    done       = (state == BUSY) & (cnt == '0);
    state_nx   = state;
    cnt_nx     = cnt;
    md_dest_nx = md_dest;
    case (state)
      IDLE: begin
        if (start) begin
          state_nx   = BUSY;
          cnt_nx     = bus.id_is_mul ? CW'(MULCYC - 1) : CW'(DIVCYC - 1);
          md_dest_nx = bus.id_dest;
        end
      end
      BUSY: begin
        if (done) state_nx = IDLE;
        else      cnt_nx   = cnt - CW'(1);
      end
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments; reset is synchronous and clears everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      md_dest     <= '0;
      stall_count <= '0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      md_dest <= md_dest_nx;
      if (stall && (stall_count != '1)) stall_count <= stall_count + CNTW'(1);
    end
  end

  assign bus.pc_stall    = stall;
  assign bus.ifid_stall  = stall;
  assign bus.idex_bubble = stall | bus.branch_taken;
  assign bus.ifid_flush  = bus.branch_taken;
  assign bus.md_start    = start;
  assign bus.md_busy     = (state == BUSY);
  assign bus.md_done     = done;
  assign bus.stall_count = stall_count;
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench: directed scenarios plus randomized traffic against a behavioural model.
module tb_hazard_stall_ctrl;
  localparam int MULCYC = 4;
  localparam int DIVCYC = 8;
  localparam int CNTW   = 16;
  localparam int CMAX   = (1 << CNTW) - 1;

  logic clk = 1'b0;
  logic rst, rst_s;
  always #5 clk = ~clk;

  hazard_stall_ctrl_if #(.CNTW(CNTW)) bus ();
  hazard_stall_ctrl_if #(.CNTW(4))    bus_s ();

  hazard_stall_ctrl #(.MULCYC(MULCYC), .DIVCYC(DIVCYC), .CNTW(CNTW)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave));
  hazard_stall_ctrl #(.MULCYC(1), .DIVCYC(2), .CNTW(4)) dut_s (
    .clk(clk), .rst(rst_s), .bus(bus_s.slave));

  int passed = 0;
  int total  = 0;

  // Model state: remaining occupancy cycles, result register, stall count.
  int       m_left;
  logic [3:0] m_dest;
  int       m_cnt;

  // {pc_stall, ifid_stall, idex_bubble, ifid_flush, md_start, md_busy, md_done}
  function automatic logic [6:0] pk(input logic s, bub, fl, st, busy, done);
    return {s, s, bub, fl, st, busy, done};
  endfunction

  function automatic logic [6:0] dut_outs();
    return {bus.pc_stall, bus.ifid_stall, bus.idex_bubble, bus.ifid_flush,
            bus.md_start, bus.md_busy, bus.md_done};
  endfunction

  function automatic logic [6:0] sat_outs();
    return {bus_s.pc_stall, bus_s.ifid_stall, bus_s.idex_bubble, bus_s.ifid_flush,
            bus_s.md_start, bus_s.md_busy, bus_s.md_done};
  endfunction

  function automatic logic [6:0] model_outs();
    logic busy, lu, bh, st, sr;
    busy = (m_left > 0);
    lu = bus.ex_memread && (bus.ex_dest == bus.id_op1 || bus.ex_dest == bus.id_op2 ||
                            (bus.id_r15use && bus.ex_dest == 4'hF));
    bh = busy && (bus.id_is_mul || bus.id_is_div || bus.id_op1 == m_dest ||
                  bus.id_op2 == m_dest || bus.id_r15use ||
                  bus.id_op1 == 4'hF || bus.id_op2 == 4'hF);
    st = bus.id_valid && !bus.branch_taken && (lu || bh);
    sr = bus.id_valid && !bus.branch_taken && !st && (bus.id_is_mul || bus.id_is_div);
    return pk(st, st || bus.branch_taken, bus.branch_taken, sr, busy, m_left == 1);
  endfunction

  task automatic idle_in();
    bus.id_valid = 0; bus.id_op1 = 0; bus.id_op2 = 0; bus.id_r15use = 0;
    bus.id_is_mul = 0; bus.id_is_div = 0; bus.id_dest = 0;
    bus.ex_memread = 0; bus.ex_dest = 0; bus.branch_taken = 0;
  endtask

  task automatic idle_in_s();
    bus_s.id_valid = 0; bus_s.id_op1 = 0; bus_s.id_op2 = 0; bus_s.id_r15use = 0;
    bus_s.id_is_mul = 0; bus_s.id_is_div = 0; bus_s.id_dest = 0;
    bus_s.ex_memread = 0; bus_s.ex_dest = 0; bus_s.branch_taken = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle_in();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_left = 0; m_dest = 0; m_cnt = 0;
  endtask

  // Advance the model across one clock edge using the inputs presented this cycle.
  task automatic model_clock();
    logic [6:0] e;
    logic r, mul;
    logic [3:0] d;
    e = model_outs(); r = rst; mul = bus.id_is_mul; d = bus.id_dest;
    @(posedge clk);
    if (r) begin
      m_left = 0; m_dest = 0; m_cnt = 0;
    end else begin
      if (e[6] && m_cnt < CMAX) m_cnt++;
      if (e[2]) begin
        m_left = mul ? MULCYC : DIVCYC;
        m_dest = d;
      end else if (m_left > 0) m_left--;
    end
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    total++;
    if (dut_outs() !== 7'b0 || bus.stall_count !== CNTW'(0))
      $display("FAIL reset outs=%b exp=0000000 cnt=%0d exp=0", dut_outs(), bus.stall_count);
    else passed++;
  endtask

  task automatic test_load_use();
    logic [6:0] e;
    do_reset();
    // id_valid=0 suppresses the stall
    bus.ex_memread = 1; bus.ex_dest = 3; bus.id_op2 = 3;
    #1;
    total++;
    if (dut_outs() !== 7'b0) $display("FAIL loaduse_invalid outs=%b exp=0000000", dut_outs());
    else passed++;
    // branch in the same cycle: flush wins
    bus.id_valid = 1; bus.branch_taken = 1;
    #1;
    total++;
    e = pk(0, 1, 1, 0, 0, 0);
    if (dut_outs() !== e) $display("FAIL loaduse_branch outs=%b exp=%b", dut_outs(), e);
    else passed++;
    bus.branch_taken = 0;
    #1;
    total++;
    e = pk(1, 1, 0, 0, 0, 0);
    if (dut_outs() !== e || bus.stall_count !== CNTW'(0))
      $display("FAIL loaduse outs=%b exp=%b cnt=%0d exp=0", dut_outs(), e, bus.stall_count);
    else passed++;
    tick();
    bus.ex_memread = 0; bus.ex_dest = 0;
    #1;
    total++;
    if (dut_outs() !== 7'b0 || bus.stall_count !== CNTW'(1))
      $display("FAIL loaduse_after outs=%b exp=0000000 cnt=%0d exp=1", dut_outs(), bus.stall_count);
    else passed++;
    // implicit R15 read against a load into R15
    bus.ex_memread = 1; bus.ex_dest = 4'hF; bus.id_op1 = 1; bus.id_op2 = 2; bus.id_r15use = 1;
    #1;
    total++;
    e = pk(1, 1, 0, 0, 0, 0);
    if (dut_outs() !== e) $display("FAIL loaduse_r15 outs=%b exp=%b", dut_outs(), e);
    else passed++;
    idle_in();
  endtask

  // Issue a mul/div at T, then hold a follow-up in ID; branch optionally at cycle br_k.
  task automatic run_md(input string name, input logic is_div, input int occ,
                        input logic nx_mul, input logic [3:0] nx_op1, input logic nx_r15,
                        input int br_k, input int rst_k);
    logic [6:0] e;
    int c;
    bit s, b;
    do_reset();
    bus.id_valid = 1; bus.id_is_mul = !is_div; bus.id_is_div = is_div; bus.id_dest = 5;
    #1;
    total++;
    e = pk(0, 0, 0, 1, 0, 0);
    if (dut_outs() !== e) $display("FAIL %s_start outs=%b exp=%b", name, dut_outs(), e);
    else passed++;
    tick();
    bus.id_is_mul = nx_mul; bus.id_is_div = 0; bus.id_dest = 6;
    bus.id_op1 = nx_op1; bus.id_r15use = nx_r15;
    c = 0;
    for (int k = 1; k <= occ + 1; k++) begin
      bus.branch_taken = (k == br_k);
      rst = (k == rst_k);
      b = (k <= occ) && (rst_k == 0 || k <= rst_k);
      s = b && (k != br_k);
      #1;
      total++;
      e = pk(s, s || (k == br_k), k == br_k, nx_mul && !b && (k != br_k), b, b && k == occ);
      if (dut_outs() !== e || bus.stall_count !== CNTW'(c))
        $display("FAIL %s k=%0d outs=%b exp=%b cnt=%0d exp=%0d",
                 name, k, dut_outs(), e, bus.stall_count, c);
      else passed++;
      c = (k == rst_k) ? 0 : c + int'(s);
      tick();
    end
    idle_in();
    rst = 0;
  endtask

  task automatic test_reset_busy();
    run_md("rst_busy", 0, MULCYC, 0, 4'd5, 0, 0, 2);
    for (int k = 0; k < 6; k++) begin
      bus.id_valid = 1; bus.id_op1 = 5;
      #1;
      total++;
      if (dut_outs() !== 7'b0 || bus.stall_count !== CNTW'(0))
        $display("FAIL rst_busy_tail k=%0d outs=%b exp=0000000 cnt=%0d exp=0",
                 k, dut_outs(), bus.stall_count);
      else passed++;
      tick();
    end
    idle_in();
  endtask

  task automatic test_random();
    logic [6:0] e;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      int r;
      bus.id_valid     = ($urandom_range(0, 7) != 0);
      bus.id_op1       = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 6));
      bus.id_op2       = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 6));
      bus.id_r15use    = ($urandom_range(0, 5) == 0);
      r                = $urandom_range(0, 5);
      bus.id_is_mul    = (r == 0);
      bus.id_is_div    = (r == 1);
      bus.id_dest      = 4'($urandom_range(0, 6));
      bus.ex_memread   = ($urandom_range(0, 2) == 0);
      bus.ex_dest      = ($urandom_range(0, 4) == 0) ? 4'hF : 4'($urandom_range(0, 6));
      bus.branch_taken = ($urandom_range(0, 9) == 0);
      rst              = ($urandom_range(0, 79) == 0);
      #1;
      e = model_outs();
      total++;
      if (dut_outs() !== e || bus.stall_count !== CNTW'(m_cnt))
        $display("FAIL random i=%0d outs=%b exp=%b cnt=%0d exp=%0d",
                 i, dut_outs(), e, bus.stall_count, m_cnt);
      else passed++;
      model_clock();
    end
    rst = 0;
    idle_in();
  endtask

  task automatic test_saturation();
    idle_in_s();
    rst_s = 1;
    tick();
    rst_s = 0;
    bus_s.ex_memread = 1; bus_s.ex_dest = 3; bus_s.id_valid = 1; bus_s.id_op1 = 3;
    for (int i = 1; i <= 20; i++) begin
      tick();
      total++;
      if (bus_s.stall_count !== 4'((i < 15) ? i : 15) || bus_s.pc_stall !== 1'b1)
        $display("FAIL saturation i=%0d cnt=%0d exp=%0d stall=%b exp=1",
                 i, bus_s.stall_count, (i < 15) ? i : 15, bus_s.pc_stall);
      else passed++;
    end
    idle_in_s();
  endtask

  task automatic test_mulcyc1();
    logic [6:0] e;
    rst_s = 1;
    tick();
    rst_s = 0;
    bus_s.id_valid = 1; bus_s.id_is_mul = 1; bus_s.id_dest = 2;
    #1;
    total++;
    e = pk(0, 0, 0, 1, 0, 0);
    if (sat_outs() !== e) $display("FAIL mulcyc1_start outs=%b exp=%b", sat_outs(), e);
    else passed++;
    tick();
    idle_in_s();
    #1;
    total++;
    e = pk(0, 0, 0, 0, 1, 1);
    if (sat_outs() !== e) $display("FAIL mulcyc1_t1 outs=%b exp=%b", sat_outs(), e);
    else passed++;
    tick();
    total++;
    if (sat_outs() !== 7'b0) $display("FAIL mulcyc1_t2 outs=%b exp=0000000", sat_outs());
    else passed++;
  endtask

  initial begin
    rst = 1; rst_s = 1;
    idle_in();
    idle_in_s();
    test_reset();
    test_load_use();
    run_md("mul_dep",     0, MULCYC, 0, 4'd5, 0, 0, 0);
    run_md("back_to_back", 0, MULCYC, 1, 4'd0, 0, 0, 0);
    run_md("div_r15",     1, DIVCYC, 0, 4'd0, 1, 0, 0);
    run_md("branch_busy", 0, MULCYC, 0, 4'd5, 0, 2, 0);
    test_reset_busy();
    test_random();
    test_saturation();
    test_mulcyc1();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
